// File: rtl/vga_fb_pkg.sv
// ----------------------------------------------------------------------------
// vga_fb_pkg
// Shared types and constants for the VGA framebuffer write controller.
//   - CPU port IDs decoded by the controller
//   - framebuffer address/data widths
//   - controller state encoding and the command FIFO entry layout
// ----------------------------------------------------------------------------
package vga_fb_pkg;

    localparam int FB_ADDR_W = 13;
    localparam int FB_DATA_W = 8;

    localparam logic [7:0] PORT_HADDR  = 8'h90;
    localparam logic [7:0] PORT_LADDR  = 8'h91;
    localparam logic [7:0] PORT_COLOR  = 8'h92;
    localparam logic [7:0] PORT_CLEAR  = 8'h94;
    localparam logic [7:0] PORT_STATUS = 8'h96;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } fb_state_t;

    // One queued CPU request: a single pixel write, or a full-screen clear
    // whose fill colour travels in the data field (addr is then unused).
    typedef struct packed {
        logic                 is_clr;
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_cmd_t;

endpackage

// File: rtl/vga_fb_write_ctrl_if.sv
// ----------------------------------------------------------------------------
// vga_fb_write_ctrl_if
// Bundles the CPU I/O port signals and the framebuffer write port.
//   IO_STRB  CPU I/O strobe (level)      PORT_ID  CPU port id
//   OUT_PORT CPU output data             FB_RD    framebuffer read data
//   FB_WA    framebuffer address         FB_WD    framebuffer write data
//   FB_WE    framebuffer write enable    RD_DATA  readback to CPU input mux
//   STATUS   {5'b0, ovf, full, busy}
// master: the CPU/framebuffer side; slave: the write controller.
// ----------------------------------------------------------------------------
interface vga_fb_write_ctrl_if
    import vga_fb_pkg::*;
;
    logic                 IO_STRB;
    logic [7:0]           PORT_ID;
    logic [7:0]           OUT_PORT;
    logic [FB_DATA_W-1:0] FB_RD;
    logic [FB_ADDR_W-1:0] FB_WA;
    logic [FB_DATA_W-1:0] FB_WD;
    logic                 FB_WE;
    logic [7:0]           RD_DATA;
    logic [7:0]           STATUS;

    modport master (
        output IO_STRB, PORT_ID, OUT_PORT, FB_RD,
        input  FB_WA, FB_WD, FB_WE, RD_DATA, STATUS
    );

    modport slave (
        input  IO_STRB, PORT_ID, OUT_PORT, FB_RD,
        output FB_WA, FB_WD, FB_WE, RD_DATA, STATUS
    );
endinterface

// File: rtl/fb_cmd_fifo.sv
// ----------------------------------------------------------------------------
// fb_cmd_fifo
// Small synchronous FIFO of fb_cmd_t entries, first-word fall-through.
//   clk_i    clock                     rst_ni   async active-low reset
//   push_i   enqueue din_i             pop_i    dequeue head
//   din_i    entry to enqueue          dout_o   current head entry
//   full_o   count == DEPTH            empty_o  count == 0
//   count_o  number of valid entries
// A push while full is accepted only when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module fb_cmd_fifo
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fb_cmd_t                  din_i,
    output fb_cmd_t                  dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fb_cmd_t          mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wrEn;
    logic             rdEn;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rdPtr_q];

    // When full, the slot being written is the one being read this cycle, so
    // letting a push through alongside a pop never overwrites a live entry.
    assign wrEn = push_i && (!full_o || pop_i);
    assign rdEn = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({wrEn, rdEn})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
            if (rdEn) rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed through count.
    always_ff @(posedge clk_i) begin
        if (wrEn) mem_q[wrPtr_q] <= din_i;
    end

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// ----------------------------------------------------------------------------
// vga_fb_write_ctrl
// Sequences all CPU access to the VGA framebuffer.
//   CLK      system clock, all logic on posedge
//   RST_N    asynchronous active-low reset
//   bus      vga_fb_write_ctrl_if.slave:
//            CPU strobe/port/data in, framebuffer read data in,
//            registered FB_WA/FB_WD/FB_WE out, RD_DATA readback, STATUS.
// CPU port writes set the current address, queue pixel writes or clear
// commands, or clear the overflow flag. Queued commands are issued at most
// one framebuffer write per cycle; a clear sweeps address 0..CLR_LAST.
// While idle FB_WA holds the CPU address so the framebuffer can be read back.
// ----------------------------------------------------------------------------
module vga_fb_write_ctrl
    import vga_fb_pkg::*;
#(
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [FB_ADDR_W-1:0] CLR_LAST   = 13'h1DFF,
    parameter logic [7:0]           HADDR_ID   = PORT_HADDR,
    parameter logic [7:0]           LADDR_ID   = PORT_LADDR,
    parameter logic [7:0]           COLOR_ID   = PORT_COLOR,
    parameter logic [7:0]           CLEAR_ID   = PORT_CLEAR,
    parameter logic [7:0]           STATUS_ID  = PORT_STATUS
) (
    input  logic                CLK,
    input  logic                RST_N,
    vga_fb_write_ctrl_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 strb_q;
    logic                 strbEdge;
    logic [FB_ADDR_W-1:0] addr_q;
    logic                 ovf_q;
    fb_state_t            state_q, state_d;
    logic                 fbWe_q, fbWe_d;
    logic [FB_ADDR_W-1:0] fbWa_q, fbWa_d;
    logic [FB_DATA_W-1:0] fbWd_q, fbWd_d;
    logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
    logic [FB_DATA_W-1:0] colour_q, colour_d;

    logic                 push;
    logic                 pop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [CW-1:0]        fifoCount;
    fb_cmd_t              pushCmd;
    fb_cmd_t              head;

    // A strobe may be held for several cycles; only its rising edge acts.
    assign strbEdge = bus.IO_STRB & ~strb_q;

    assign push            = strbEdge && (bus.PORT_ID == COLOR_ID || bus.PORT_ID == CLEAR_ID);
    assign pushCmd.is_clr  = (bus.PORT_ID == CLEAR_ID);
    assign pushCmd.addr    = addr_q;
    assign pushCmd.data    = bus.OUT_PORT;

    fb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pushCmd),
        .dout_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Strobe history, CPU address register and sticky overflow flag.
    // An overflow in the same cycle as a status clear leaves ovf set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            strb_q <= 1'b0;
            addr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            strb_q <= bus.IO_STRB;
            if (strbEdge && bus.PORT_ID == HADDR_ID) addr_q[12:7] <= bus.OUT_PORT[5:0];
            if (strbEdge && bus.PORT_ID == LADDR_ID) addr_q[6:0]  <= bus.OUT_PORT[6:0];
            if (strbEdge && bus.PORT_ID == STATUS_ID) ovf_q <= 1'b0;
            if (push && fifoFull && !pop) ovf_q <= 1'b1;
        end
    end

    // Issue state: pops one command per cycle in IDLE/WRITE; a clear command
    // parks the FSM in CLEAR until the whole screen has been swept, during
    // which the FIFO keeps accepting (but not issuing) commands.
    always_comb begin
        state_d  = state_q;
        fbWe_d   = 1'b0;
        fbWa_d   = addr_q;
        fbWd_d   = fbWd_q;
        cnt_d    = cnt_q;
        colour_d = colour_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (!fifoEmpty) begin
                    pop = 1'b1;
                    if (head.is_clr) begin
                        cnt_d    = '0;
                        colour_d = head.data;
                        state_d  = CLEAR;
                    end else begin
                        fbWe_d  = 1'b1;
                        fbWa_d  = head.addr;
                        fbWd_d  = head.data;
                        state_d = WRITE;
                    end
                end
            end
            CLEAR: begin
                fbWe_d = 1'b1;
                fbWa_d = cnt_q;
                fbWd_d = colour_q;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CLR_LAST) begin
                    state_d = fifoEmpty ? IDLE : WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            fbWe_q   <= 1'b0;
            fbWa_q   <= '0;
            fbWd_q   <= '0;
            cnt_q    <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            fbWe_q   <= fbWe_d;
            fbWa_q   <= fbWa_d;
            fbWd_q   <= fbWd_d;
            cnt_q    <= cnt_d;
            colour_q <= colour_d;
        end
    end

    assign bus.FB_WE   = fbWe_q;
    assign bus.FB_WA   = fbWa_q;
    assign bus.FB_WD   = fbWd_q;
    assign bus.RD_DATA = bus.FB_RD;
    assign bus.STATUS  = {5'b0, ovf_q, fifoFull, (state_q != IDLE) || (fifoCount != '0)};

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_fb_write_ctrl
// Self-checking bench for vga_fb_write_ctrl. A monitor records every
// framebuffer write; each test builds the list of writes it expects from the
// controller's documented behaviour and compares the two lists.
// ----------------------------------------------------------------------------
module tb_vga_fb_write_ctrl;

    localparam logic [7:0] HADDR  = 8'h90;
    localparam logic [7:0] LADDR  = 8'h91;
    localparam logic [7:0] COLOR  = 8'h92;
    localparam logic [7:0] CLEARP = 8'h94;
    localparam logic [7:0] STATP  = 8'h96;
    localparam int         SWEEP  = 7680;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    always #5 CLK = ~CLK;

    vga_fb_write_ctrl_if bus ();

    vga_fb_write_ctrl #(
        .FIFO_DEPTH (4),
        .CLR_LAST   (13'h1DFF)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checkCnt = 0;
    int passCnt  = 0;
    int cycle    = 0;

    logic [12:0] obsWa [$];
    logic [7:0]  obsWd [$];
    int          obsCyc[$];
    logic [12:0] expWa [$];
    logic [7:0]  expWd [$];
    logic [12:0] modelAddr;

    always @(posedge CLK) cycle++;

    // Write monitor: one record per cycle with FB_WE high.
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus.FB_WE === 1'b1) begin
            obsWa.push_back(bus.FB_WA);
            obsWd.push_back(bus.FB_WD);
            obsCyc.push_back(cycle);
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void clearLists();
        obsWa.delete(); obsWd.delete(); obsCyc.delete();
        expWa.delete(); expWd.delete();
    endfunction

    function automatic void expectClear(input logic [7:0] colour);
        for (int a = 0; a < SWEEP; a++) begin
            expWa.push_back(13'(a));
            expWd.push_back(colour);
        end
    endfunction

    function automatic int countDiffs();
        int n = (obsWa.size() < expWa.size()) ? obsWa.size() : expWa.size();
        int d = (obsWa.size() > expWa.size()) ? obsWa.size() - expWa.size()
                                              : expWa.size() - obsWa.size();
        for (int i = 0; i < n; i++)
            if (obsWa[i] !== expWa[i] || obsWd[i] !== expWd[i]) d++;
        return d;
    endfunction

    // Called at a negedge; returns at a negedge with the strobe low.
    task automatic doWrite(input logic [7:0] id, input logic [7:0] data, input int hold);
        bus.PORT_ID  = id;
        bus.OUT_PORT = data;
        bus.IO_STRB  = 1'b1;
        repeat (hold) @(negedge CLK);
        bus.IO_STRB = 1'b0;
        @(negedge CLK);
        if (id == HADDR) modelAddr[12:7] = data[5:0];
        if (id == LADDR) modelAddr[6:0]  = data[6:0];
    endtask

    task automatic waitIdle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (bus.STATUS[0] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        bus.IO_STRB = 1'b0; bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.FB_RD = 8'h00;
        modelAddr = '0;
        #1 RST_N = 1'b0;
        #2;
        checkCnt++; if (bus.FB_WE !== 1'b0) $display("[TB] FAIL reset_we: got %b want 0", bus.FB_WE); else passCnt++;
        checkCnt++; if (bus.FB_WA !== 13'h0) $display("[TB] FAIL reset_wa: got %h want 0", bus.FB_WA); else passCnt++;
        checkCnt++; if (bus.FB_WD !== 8'h0) $display("[TB] FAIL reset_wd: got %h want 0", bus.FB_WD); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL reset_status: got %h want 00", bus.STATUS); else passCnt++;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        rd = 8'($urandom);
        bus.FB_RD = rd;
        @(negedge CLK);
        checkCnt++; if (bus.RD_DATA !== rd) $display("[TB] FAIL rd_passthrough: got %h want %h", bus.RD_DATA, rd); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL post_reset_status: got %h want 00", bus.STATUS); else passCnt++;
    endtask

    task automatic test_single_pixel();
        doWrite(HADDR, 8'h05, 1);
        doWrite(LADDR, 8'h0A, 1);
        clearLists();
        bus.PORT_ID = COLOR; bus.OUT_PORT = 8'hE0; bus.IO_STRB = 1'b1;
        @(negedge CLK);
        checkCnt++; if (bus.FB_WE !== 1'b0) $display("[TB] FAIL pixel_early_we: got %b want 0", bus.FB_WE); else passCnt++;
        bus.IO_STRB = 1'b0;
        @(negedge CLK);
        checkCnt++; if (bus.FB_WE !== 1'b1) $display("[TB] FAIL pixel_we: got %b want 1", bus.FB_WE); else passCnt++;
        checkCnt++; if (bus.FB_WA !== 13'h028A) $display("[TB] FAIL pixel_wa: got %h want 028a", bus.FB_WA); else passCnt++;
        checkCnt++; if (bus.FB_WD !== 8'hE0) $display("[TB] FAIL pixel_wd: got %h want e0", bus.FB_WD); else passCnt++;
        @(negedge CLK);
        checkCnt++; if (bus.FB_WE !== 1'b0) $display("[TB] FAIL pixel_we_end: got %b want 0", bus.FB_WE); else passCnt++;
        checkCnt++; if (bus.FB_WA !== 13'h028A) $display("[TB] FAIL idle_wa: got %h want 028a", bus.FB_WA); else passCnt++;
        checkCnt++; if (obsWa.size() != 1) $display("[TB] FAIL pixel_pulses: got %0d want 1", obsWa.size()); else passCnt++;
    endtask

    task automatic test_held_strobe();
        bit ok;
        clearLists();
        expWa.push_back(modelAddr); expWd.push_back(8'h5A);
        doWrite(COLOR, 8'h5A, 3);
        waitIdle(20, ok);
        checkCnt++; if (!ok) $display("[TB] FAIL held_idle: busy still %b want 0", bus.STATUS[0]); else passCnt++;
        checkCnt++; if (countDiffs() != 0) $display("[TB] FAIL held_writes: got %0d writes want 1 (diffs %0d)", obsWa.size(), countDiffs()); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL held_status: got %h want 00", bus.STATUS); else passCnt++;
    endtask

    task automatic test_mid_run_reset();
        doWrite(COLOR, 8'h33, 1);
        checkCnt++; if (bus.FB_WE !== 1'b1) $display("[TB] FAIL midrst_pre_we: got %b want 1", bus.FB_WE); else passCnt++;
        #2 RST_N = 1'b0;
        #1;
        checkCnt++; if (bus.FB_WE !== 1'b0) $display("[TB] FAIL midrst_we: got %b want 0", bus.FB_WE); else passCnt++;
        checkCnt++; if (bus.FB_WA !== 13'h0) $display("[TB] FAIL midrst_wa: got %h want 0", bus.FB_WA); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL midrst_status: got %h want 00", bus.STATUS); else passCnt++;
        @(negedge CLK);
        RST_N = 1'b1;
        modelAddr = '0;
        @(negedge CLK);
    endtask

    task automatic test_clear_then_pixel();
        bit done = 1'b0;
        clearLists();
        expectClear(8'h03);
        expWa.push_back(13'h0); expWd.push_back(8'h1C);
        doWrite(CLEARP, 8'h03, 1);
        doWrite(HADDR, 8'h00, 1);
        doWrite(LADDR, 8'h00, 1);
        doWrite(COLOR, 8'h1C, 1);
        for (int i = 0; i < 9000; i++) begin
            @(negedge CLK);
            if (bus.STATUS[0] !== 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        checkCnt++; if (!done) $display("[TB] FAIL clear_done: busy %b after budget want 0", bus.STATUS[0]); else passCnt++;
        checkCnt++; if (obsWa.size() != SWEEP + 1) $display("[TB] FAIL clear_busy_count: got %0d writes while busy want %0d", obsWa.size(), SWEEP + 1); else passCnt++;
        checkCnt++; if (countDiffs() != 0) $display("[TB] FAIL clear_sequence: got %0d differing writes want 0", countDiffs()); else passCnt++;
        checkCnt++;
        if (obsCyc.size() == 0 || obsCyc[obsCyc.size()-1] - obsCyc[0] != SWEEP)
            $display("[TB] FAIL clear_contiguous: got span %0d want %0d", obsCyc.size() ? obsCyc[obsCyc.size()-1] - obsCyc[0] : -1, SWEEP);
        else passCnt++;
    endtask

    task automatic test_back_to_back_overflow();
        bit ok;
        logic [7:0] colour, d;
        doWrite(HADDR, 8'($urandom_range(0, 59)), 1);
        clearLists();
        colour = 8'($urandom);
        expectClear(colour);
        doWrite(CLEARP, colour, 1);
        for (int k = 0; k < 5; k++) begin
            doWrite(LADDR, 8'($urandom), 1);
            d = 8'($urandom);
            if (k < 4) begin
                expWa.push_back(modelAddr); expWd.push_back(d);
            end
            doWrite(COLOR, d, 1);
        end
        checkCnt++; if (bus.STATUS !== 8'h07) $display("[TB] FAIL ovf_status: got %h want 07", bus.STATUS); else passCnt++;
        waitIdle(9000, ok);
        checkCnt++; if (!ok) $display("[TB] FAIL ovf_idle: busy %b want 0", bus.STATUS[0]); else passCnt++;
        checkCnt++; if (countDiffs() != 0) $display("[TB] FAIL ovf_sequence: got %0d writes, %0d diffs want %0d writes, 0 diffs", obsWa.size(), countDiffs(), SWEEP + 4); else passCnt++;
        checkCnt++;
        if (obsCyc.size() == 0 || obsCyc[obsCyc.size()-1] - obsCyc[0] != SWEEP + 3)
            $display("[TB] FAIL back_to_back: got span %0d want %0d", obsCyc.size() ? obsCyc[obsCyc.size()-1] - obsCyc[0] : -1, SWEEP + 3);
        else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h04) $display("[TB] FAIL ovf_sticky: got %h want 04", bus.STATUS); else passCnt++;
        doWrite(STATP, 8'($urandom), 1);
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL ovf_clear: got %h want 00", bus.STATUS); else passCnt++;
    endtask

    task automatic test_reset_mid_clear();
        bit found = 1'b0;
        doWrite(CLEARP, 8'($urandom), 1);
        doWrite(COLOR, 8'($urandom), 1);
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (bus.FB_WE === 1'b1 && bus.FB_WA === 13'd100) begin
                found = 1'b1;
                break;
            end
        end
        checkCnt++; if (!found) $display("[TB] FAIL sweep_cnt100: got wa %h want 0064 during sweep", bus.FB_WA); else passCnt++;
        #1 RST_N = 1'b0;
        #1;
        checkCnt++; if (bus.FB_WE !== 1'b0) $display("[TB] FAIL sweeprst_we: got %b want 0", bus.FB_WE); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL sweeprst_status: got %h want 00", bus.STATUS); else passCnt++;
        @(negedge CLK);
        RST_N = 1'b1;
        modelAddr = '0;
        clearLists();
        repeat (30) @(negedge CLK);
        checkCnt++; if (obsWa.size() != 0) $display("[TB] FAIL sweeprst_writes: got %0d writes want 0", obsWa.size()); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL sweeprst_status_after: got %h want 00", bus.STATUS); else passCnt++;
    endtask

    task automatic test_random_traffic();
        bit ok;
        int op;
        logic [7:0] id, d;
        clearLists();
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            d  = 8'($urandom);
            if (op <= 2) id = HADDR;
            else if (op <= 4) id = LADDR;
            else if (op <= 7) id = COLOR;
            else if (op == 8) id = STATP;
            else begin
                id = 8'($urandom);
                while (id == HADDR || id == LADDR || id == COLOR || id == CLEARP || id == STATP)
                    id = 8'($urandom);
            end
            if (id == COLOR) begin
                expWa.push_back(modelAddr); expWd.push_back(d);
            end
            doWrite(id, d, $urandom_range(1, 3));
        end
        waitIdle(50, ok);
        checkCnt++; if (!ok) $display("[TB] FAIL rand_idle: busy %b want 0", bus.STATUS[0]); else passCnt++;
        checkCnt++; if (countDiffs() != 0) $display("[TB] FAIL rand_writes: got %0d writes, %0d diffs want %0d writes", obsWa.size(), countDiffs(), expWa.size()); else passCnt++;
        @(negedge CLK);
        checkCnt++; if (bus.FB_WA !== modelAddr) $display("[TB] FAIL rand_idle_wa: got %h want %h", bus.FB_WA, modelAddr); else passCnt++;
        checkCnt++; if (bus.STATUS !== 8'h00) $display("[TB] FAIL rand_status: got %h want 00", bus.STATUS); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_held_strobe();
        test_mid_run_reset();
        test_random_traffic();
        test_clear_then_pixel();
        test_back_to_back_overflow();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
